// File: rtl/ddr3_pkg.sv
// Shared DDR3 line/command definitions for the cache stage and the MIG app bridge.
package ddr3_pkg;

  // MIG native app_cmd encodings
  localparam logic [2:0] APP_CMD_WRITE = 3'b000;
  localparam logic [2:0] APP_CMD_READ  = 3'b001;

  // One cache line is one BL8 burst on the x32 DDR3
  localparam int unsigned LINE_BYTES       = 32;
  localparam int unsigned LINE_OFFSET_BITS = 5;

  // Bridge FSM encoding
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR      = 3'd1,
    ST_RD_CMD  = 3'd2,
    ST_RD_WAIT = 3'd3,
    ST_DONE    = 3'd4
  } bridge_state_t;

endpackage : ddr3_pkg

// File: rtl/ddr3_app_bridge.sv
// Converts single-outstanding cache-line requests into MIG 7-series app commands.
// Everything runs on the MIG ui_clk; all app-side outputs come straight from flops.
module ddr3_app_bridge
  import ddr3_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 29,
  parameter int unsigned APP_ADDR_WIDTH = 28,
  parameter int unsigned DATA_WIDTH     = 256,
  parameter int unsigned RD_TIMEOUT     = 1023
) (
  input  logic                      clk,
  input  logic                      rst,
  // cache-line request side
  input  logic [ADDR_WIDTH-1:0]     addr_i,
  input  logic [DATA_WIDTH-1:0]     data_i,
  input  logic                      we_i,
  input  logic                      rd_i,
  output logic [DATA_WIDTH-1:0]     data_o,
  output logic                      ack_o,
  output logic                      err_o,
  // MIG app interface
  input  logic                      calib_done_i,
  output logic [APP_ADDR_WIDTH-1:0] app_addr,
  output logic [2:0]                app_cmd,
  output logic                      app_en,
  input  logic                      app_rdy,
  output logic [DATA_WIDTH-1:0]     app_wdf_data,
  output logic                      app_wdf_wren,
  output logic                      app_wdf_end,
  output logic [DATA_WIDTH/8-1:0]   app_wdf_mask,
  input  logic                      app_wdf_rdy,
  input  logic [DATA_WIDTH-1:0]     app_rd_data,
  input  logic                      app_rd_data_valid,
  input  logic                      app_rd_data_end
);

  // app_addr counts 32-bit DQ words, so a line address drops 2 more bits
  localparam int unsigned WORD_SEL_BITS = LINE_OFFSET_BITS - 2;
  localparam int unsigned CNT_W         = $clog2(RD_TIMEOUT + 1);

  bridge_state_t state, state_nxt;

  logic [CNT_W-1:0]          cnt_q, cnt_nxt;
  logic                      cmd_done_q, cmd_done_nxt;
  logic                      data_done_q, data_done_nxt;
  logic                      en_nxt, wren_nxt, ack_nxt, err_nxt;
  logic [APP_ADDR_WIDTH-1:0] addr_nxt;
  logic [2:0]                cmd_nxt;
  logic [DATA_WIDTH-1:0]     wdata_nxt, rdata_nxt;

  logic                      req_take;
  logic                      cmd_hs, data_hs;
  logic                      cmd_ok, data_ok;
  logic                      rd_hit, tmo_hit;
  logic [APP_ADDR_WIDTH-1:0] line_app_addr;
  logic                      unused_ok;

  // Requests are only taken in IDLE once the MIG has calibrated
  assign req_take = (state == ST_IDLE) && calib_done_i && !ack_o && (we_i || rd_i);

  assign cmd_hs  = app_en && app_rdy;
  assign data_hs = app_wdf_wren && app_wdf_rdy;
  assign cmd_ok  = cmd_done_q || cmd_hs;
  assign data_ok = data_done_q || data_hs;

  assign rd_hit  = app_rd_data_valid && app_rd_data_end;
  assign tmo_hit = !rd_hit && (cnt_q == CNT_W'(RD_TIMEOUT - 1));

  assign line_app_addr = APP_ADDR_WIDTH'({addr_i[ADDR_WIDTH-1:LINE_OFFSET_BITS],
                                          {WORD_SEL_BITS{1'b0}}});

  // Byte offset within the line carries no information for a full-line transfer
  assign unused_ok = ^addr_i[LINE_OFFSET_BITS-1:0];

  // Full lines only, never masked
  assign app_wdf_mask = '0;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (calib_done_i && !ack_o) begin
          if (we_i)      state_nxt = ST_WR;
          else if (rd_i) state_nxt = ST_RD_CMD;
        end
      end
      ST_WR:      if (cmd_ok && data_ok)  state_nxt = ST_DONE;
      ST_RD_CMD:  if (cmd_hs)             state_nxt = ST_RD_WAIT;
      ST_RD_WAIT: if (rd_hit || tmo_hit)  state_nxt = ST_DONE;
      ST_DONE:                            state_nxt = ST_IDLE;
      default:                            state_nxt = ST_IDLE;
    endcase
  end

  // Output/datapath next values; strobes drop the cycle after their handshake
  always_comb begin
    en_nxt        = app_en;
    wren_nxt      = app_wdf_wren;
    cmd_done_nxt  = cmd_done_q;
    data_done_nxt = data_done_q;
    err_nxt       = err_o;
    cnt_nxt       = cnt_q;
    addr_nxt      = app_addr;
    cmd_nxt       = app_cmd;
    wdata_nxt     = app_wdf_data;
    rdata_nxt     = data_o;
    ack_nxt       = (state_nxt == ST_DONE);

    case (state)
      ST_IDLE: begin
        if (req_take) begin
          addr_nxt      = line_app_addr;
          wdata_nxt     = data_i;
          cmd_done_nxt  = 1'b0;
          data_done_nxt = 1'b0;
          en_nxt        = 1'b1;
          // write wins when both are requested
          if (we_i) begin
            cmd_nxt  = APP_CMD_WRITE;
            wren_nxt = 1'b1;
          end else begin
            cmd_nxt  = APP_CMD_READ;
          end
        end
      end
      ST_WR: begin
        if (cmd_hs) begin
          en_nxt       = 1'b0;
          cmd_done_nxt = 1'b1;
        end
        if (data_hs) begin
          wren_nxt      = 1'b0;
          data_done_nxt = 1'b1;
        end
      end
      ST_RD_CMD: begin
        if (cmd_hs) begin
          en_nxt  = 1'b0;
          cnt_nxt = '0;
        end
      end
      ST_RD_WAIT: begin
        if (rd_hit) begin
          rdata_nxt = app_rd_data;
        end else begin
          cnt_nxt = cnt_q + CNT_W'(1);
          if (tmo_hit) err_nxt = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Output and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_o        <= 1'b0;
      err_o        <= 1'b0;
      app_en       <= 1'b0;
      app_wdf_wren <= 1'b0;
      app_wdf_end  <= 1'b0;
      app_addr     <= '0;
      app_cmd      <= APP_CMD_READ;
      app_wdf_data <= '0;
      data_o       <= '0;
      cnt_q        <= '0;
      cmd_done_q   <= 1'b0;
      data_done_q  <= 1'b0;
    end else begin
      ack_o        <= ack_nxt;
      err_o        <= err_nxt;
      app_en       <= en_nxt;
      app_wdf_wren <= wren_nxt;
      app_wdf_end  <= wren_nxt;
      app_addr     <= addr_nxt;
      app_cmd      <= cmd_nxt;
      app_wdf_data <= wdata_nxt;
      data_o       <= rdata_nxt;
      cnt_q        <= cnt_nxt;
      cmd_done_q   <= cmd_done_nxt;
      data_done_q  <= data_done_nxt;
    end
  end

endmodule : ddr3_app_bridge

// File: tb/tb_ddr3_app_bridge.sv
// Directed bench for ddr3_app_bridge: vector table plus calib, reset and timeout sequences.
module tb_ddr3_app_bridge;

  logic          clk = 1'b0;
  logic          rst;
  logic [28:0]   addr_i;
  logic [255:0]  data_i;
  logic          we_i, rd_i;
  logic [255:0]  data_o;
  logic          ack_o, err_o;
  logic          calib_done_i;
  logic [27:0]   app_addr;
  logic [2:0]    app_cmd;
  logic          app_en, app_rdy;
  logic [255:0]  app_wdf_data;
  logic          app_wdf_wren, app_wdf_end;
  logic [31:0]   app_wdf_mask;
  logic          app_wdf_rdy;
  logic [255:0]  app_rd_data;
  logic          app_rd_data_valid, app_rd_data_end;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ddr3_app_bridge #(.RD_TIMEOUT(15)) dut (
    .clk               (clk),
    .rst               (rst),
    .addr_i            (addr_i),
    .data_i            (data_i),
    .we_i              (we_i),
    .rd_i              (rd_i),
    .data_o            (data_o),
    .ack_o             (ack_o),
    .err_o             (err_o),
    .calib_done_i      (calib_done_i),
    .app_addr          (app_addr),
    .app_cmd           (app_cmd),
    .app_en            (app_en),
    .app_rdy           (app_rdy),
    .app_wdf_data      (app_wdf_data),
    .app_wdf_wren      (app_wdf_wren),
    .app_wdf_end       (app_wdf_end),
    .app_wdf_mask      (app_wdf_mask),
    .app_wdf_rdy       (app_wdf_rdy),
    .app_rd_data       (app_rd_data),
    .app_rd_data_valid (app_rd_data_valid),
    .app_rd_data_end   (app_rd_data_end)
  );

  typedef struct {
    logic         we;
    logic         rd;
    logic [28:0]  addr;
    logic [255:0] wdata;
    logic [255:0] rdata;
    int           cmd_stall;  // cycles of app_rdy low at start of the command
    int           wdf_stall;  // cycles of app_wdf_rdy low at start of the write
    int           rd_lat;     // cycles from command acceptance to read data, 0 = never
    logic [27:0]  exp_addr;
    logic [2:0]   exp_cmd;
    int           exp_ack;    // ack cycle counted from the sampling edge
    int           exp_en;     // cycles app_en is high
    int           exp_wr;     // cycles app_wdf_wren is high
    logic [255:0] exp_data;   // data_o during and after ack
    logic         exp_err;
  } vec_t;

  localparam int NVEC = 8;
  vec_t vecs [NVEC];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic rd, input logic [28:0] addr,
                              input logic [255:0] wdata, input logic [255:0] rdata,
                              input int cs, input int ws, input int lat,
                              input logic [27:0] ea, input logic [2:0] ec, input int eack,
                              input int een, input int ewr, input logic [255:0] ed,
                              input logic ee);
    vec_t v;
    v.we = we; v.rd = rd; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
    v.cmd_stall = cs; v.wdf_stall = ws; v.rd_lat = lat;
    v.exp_addr = ea; v.exp_cmd = ec; v.exp_ack = eack; v.exp_en = een; v.exp_wr = ewr;
    v.exp_data = ed; v.exp_err = ee;
    return v;
  endfunction

  // Drives one request and plays the MIG side, then checks strobes, handshakes and timing
  task automatic run_txn(input int idx, input vec_t v);
    int acc = 0, ack_c = 0, n_en = 0, n_wr = 0, hs_cmd = 0, hs_dat = 0, n_ack = 0;
    bit first_en = 1'b1, end_bad = 1'b0;
    logic [27:0]  seen_addr = '0;
    logic [2:0]   seen_cmd = '0;
    logic [255:0] seen_wd = '0;
    we_i = v.we; rd_i = v.rd; addr_i = v.addr; data_i = v.wdata;
    app_rd_data = v.rdata;
    app_rdy = 1'b0; app_wdf_rdy = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      if (ack_c != 0 && c == ack_c + 1) begin
        we_i = 1'b0; rd_i = 1'b0;
      end
      app_rdy     = (c > v.cmd_stall);
      app_wdf_rdy = (c > v.wdf_stall);
      if (app_en) begin
        n_en++;
        if (first_en) begin
          seen_addr = app_addr; seen_cmd = app_cmd; seen_wd = app_wdf_data;
          first_en = 1'b0;
        end
        if (app_rdy) begin
          hs_cmd++;
          if (app_cmd == 3'b001) acc = c;
        end
      end
      if (app_wdf_wren) begin
        n_wr++;
        if (app_wdf_rdy) hs_dat++;
      end
      if (app_wdf_end !== app_wdf_wren) end_bad = 1'b1;
      app_rd_data_valid = (acc != 0 && v.rd_lat != 0 && c == acc + v.rd_lat);
      app_rd_data_end   = app_rd_data_valid;
      if (ack_o) begin
        n_ack++;
        if (ack_c == 0) begin
          ack_c = c;
          chk($sformatf("v%0d data_at_ack", idx), data_o, v.exp_data);
          chk($sformatf("v%0d err_at_ack", idx), 256'(err_o), 256'(v.exp_err));
        end
      end
      if (ack_c != 0 && c >= ack_c + 4) break;
    end
    app_rd_data_valid = 1'b0; app_rd_data_end = 1'b0;
    we_i = 1'b0; rd_i = 1'b0;
    chk($sformatf("v%0d ack_cycle", idx), 256'(ack_c), 256'(v.exp_ack));
    chk($sformatf("v%0d ack_count", idx), 256'(n_ack), 256'(1));
    chk($sformatf("v%0d app_addr", idx), 256'(seen_addr), 256'(v.exp_addr));
    chk($sformatf("v%0d app_cmd", idx), 256'(seen_cmd), 256'(v.exp_cmd));
    chk($sformatf("v%0d en_cycles", idx), 256'(n_en), 256'(v.exp_en));
    chk($sformatf("v%0d wren_cycles", idx), 256'(n_wr), 256'(v.exp_wr));
    chk($sformatf("v%0d cmd_handshakes", idx), 256'(hs_cmd), 256'(1));
    chk($sformatf("v%0d data_handshakes", idx), 256'(hs_dat), 256'(v.we ? 1 : 0));
    chk($sformatf("v%0d wdf_end_tracks_wren", idx), 256'(end_bad), 256'(0));
    chk($sformatf("v%0d data_held", idx), data_o, v.exp_data);
    if (v.we) chk($sformatf("v%0d app_wdf_data", idx), seen_wd, v.wdata);
  endtask

  initial begin
    int n_en, n_ack;
    bit got_en;
    logic [255:0] l_a5, l_5a, l_c3, l_3c, l_0123, l_dead, l_cafe, l_1111;
    l_a5   = {32{8'hA5}};
    l_5a   = {32{8'h5A}};
    l_c3   = {16{16'hC3C3}};
    l_3c   = {32{8'h3C}};
    l_0123 = {4{64'h0123_4567_89AB_CDEF}};
    l_dead = {8{32'hDEAD_BEEF}};
    l_cafe = {8{32'hCAFE_F00D}};
    l_1111 = {64{4'h1}};

    //           we    rd    addr          wdata  rdata   cs ws lat exp_addr      cmd     ack en wr data    err
    vecs[0] = mk(1'b1, 1'b0, 29'h0000_1234, l_a5, '0,     0, 0, 0,  28'h000_0488, 3'b000, 2,  1, 1, '0,     1'b0);
    vecs[1] = mk(1'b1, 1'b0, 29'h0ABC_DEF0, l_5a, '0,     2, 5, 0,  28'h2AF_37B8, 3'b000, 7,  3, 6, '0,     1'b0);
    vecs[2] = mk(1'b1, 1'b0, 29'h0000_0400, l_c3, '0,     4, 1, 0,  28'h000_0100, 3'b000, 6,  5, 2, '0,     1'b0);
    vecs[3] = mk(1'b0, 1'b1, 29'h1FFF_FFE0, '0,   l_0123, 3, 0, 12, 28'h7FF_FFF8, 3'b001, 17, 4, 0, l_0123, 1'b0);
    vecs[4] = mk(1'b0, 1'b1, 29'h0000_0020, '0,   l_dead, 0, 0, 1,  28'h000_0008, 3'b001, 3,  1, 0, l_dead, 1'b0);
    vecs[5] = mk(1'b0, 1'b1, 29'h0000_0040, '0,   l_0123, 0, 0, 0,  28'h000_0010, 3'b001, 17, 1, 0, l_dead, 1'b1);
    vecs[6] = mk(1'b0, 1'b1, 29'h0000_007F, '0,   l_cafe, 0, 0, 2,  28'h000_0018, 3'b001, 4,  1, 0, l_cafe, 1'b1);
    vecs[7] = mk(1'b1, 1'b1, 29'h0000_0080, l_3c, '0,     0, 0, 0,  28'h000_0020, 3'b000, 2,  1, 1, l_cafe, 1'b1);

    rst = 1'b1; calib_done_i = 1'b1;
    addr_i = '0; data_i = '0; we_i = 1'b0; rd_i = 1'b0;
    app_rdy = 1'b0; app_wdf_rdy = 1'b0;
    app_rd_data = '0; app_rd_data_valid = 1'b0; app_rd_data_end = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // reset values
    chk("rst ack_o", 256'(ack_o), 256'(0));
    chk("rst err_o", 256'(err_o), 256'(0));
    chk("rst app_en", 256'(app_en), 256'(0));
    chk("rst app_wdf_wren", 256'(app_wdf_wren), 256'(0));
    chk("rst app_wdf_end", 256'(app_wdf_end), 256'(0));
    chk("rst data_o", data_o, '0);
    chk("rst app_addr", 256'(app_addr), 256'(0));
    chk("rst app_cmd", 256'(app_cmd), 256'(3'b001));
    chk("rst app_wdf_mask", 256'(app_wdf_mask), 256'(0));
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) run_txn(i, vecs[i]);

    // calibration not done: read held for 20 cycles must not issue
    calib_done_i = 1'b0; rd_i = 1'b1; addr_i = 29'h0000_0100; app_rdy = 1'b1;
    n_en = 0; n_ack = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (app_en) n_en++;
      if (ack_o) n_ack++;
    end
    chk("calib_low app_en", 256'(n_en), 256'(0));
    chk("calib_low ack", 256'(n_ack), 256'(0));
    calib_done_i = 1'b1;
    run_txn(8, mk(1'b0, 1'b1, 29'h0000_0100, '0, l_1111, 0, 0, 1,
                  28'h000_0040, 3'b001, 3, 1, 0, l_1111, 1'b1));

    // reset during RD_WAIT, then stale read data must be ignored
    rd_i = 1'b1; addr_i = 29'h0000_0200; app_rdy = 1'b1;
    got_en = 1'b0;
    for (int c = 0; c < 10 && !got_en; c++) begin
      @(posedge clk); #1;
      if (app_en) got_en = 1'b1;
    end
    chk("rstmid cmd_issued", 256'(got_en), 256'(1));
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; rd_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rstmid app_en", 256'(app_en), 256'(0));
    chk("rstmid ack_o", 256'(ack_o), 256'(0));
    app_rd_data = {64{4'hF}}; app_rd_data_valid = 1'b1; app_rd_data_end = 1'b1;
    @(posedge clk); #1;
    app_rd_data_valid = 1'b0; app_rd_data_end = 1'b0;
    n_en = 0; n_ack = 0;
    for (int c = 0; c < 5; c++) begin
      if (app_en) n_en++;
      if (ack_o) n_ack++;
      @(posedge clk); #1;
    end
    chk("rstmid no_ack", 256'(n_ack), 256'(0));
    chk("rstmid no_cmd", 256'(n_en), 256'(0));
    chk("rstmid data_o", data_o, '0);
    chk("rstmid err_o", 256'(err_o), 256'(0));
    chk("rstmid app_cmd", 256'(app_cmd), 256'(3'b001));
    chk("rstmid app_addr", 256'(app_addr), 256'(0));
    chk("rstmid app_wdf_wren", 256'(app_wdf_wren), 256'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_ddr3_app_bridge
